// File: rtl/move_entry_if.sv
// Bundles the rx byte stream, the game-FSM move handshake and the echo tx handshake of move_entry.
// slave = the move parser itself; master = whatever drives it (UART rx, game FSM, UART tx).
interface move_entry_if;
  logic [7:0] i_rx_data;
  logic       i_rx_stb;
  logic       i_need_input;
  logic [3:0] o_move;
  logic       o_move_stb;
  logic       o_busy;
  logic [7:0] o_tx_data;
  logic       o_tx_stb;
  logic       i_tx_busy;

  modport slave (
    input  i_rx_data, i_rx_stb, i_need_input, i_tx_busy,
    output o_move, o_move_stb, o_busy, o_tx_data, o_tx_stb
  );

  modport master (
    output i_rx_data, i_rx_stb, i_need_input, i_tx_busy,
    input  o_move, o_move_stb, o_busy, o_tx_data, o_tx_stb
  );
endinterface

// File: rtl/move_entry.sv
// Keystroke-to-move parser: digit '1'..'9' with backspace, Enter delivers a square index strobe.
// Optional keystroke echo through the UART transmitter when MOVE_ENTRY_ECHO_EN is defined.
module move_entry (
  input  logic        i_clk,
  input  logic        i_rst_n,
  move_entry_if.slave bus
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_DIGIT = 3'd1;
  localparam logic [2:0] ST_WAIT_ENTER = 3'd2;
  localparam logic [2:0] ST_DELIVER    = 3'd3;
  localparam logic [2:0] ST_HOLD       = 3'd4;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_DEL   = 8'h7F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ONE   = 8'h31;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  logic [2:0]      state_q, state_d;
  logic [3:0]      pending_q, pending_d;
  logic [3:0]      move_q;
  logic            move_stb_q, move_stb_d;

  logic            q_busy;
  logic            rx_valid;
  logic            is_digit, is_bs, is_enter;
  logic [3:0]      digit_idx;

  logic            push;
  logic [1:0]      push_n;
  logic [2:0][7:0] push_bytes;

  // A byte that arrives while echoes are still draining is dropped outright.
  assign rx_valid  = bus.i_rx_stb && !q_busy;
  assign is_digit  = (bus.i_rx_data >= ASCII_ONE) && (bus.i_rx_data <= ASCII_NINE);
  assign is_bs     = (bus.i_rx_data == ASCII_BS) || (bus.i_rx_data == ASCII_DEL);
  assign is_enter  = (bus.i_rx_data == ASCII_CR) || (bus.i_rx_data == ASCII_LF);
  assign digit_idx = bus.i_rx_data[3:0] - 4'd1;

  // NOTE: every output of this block gets a default first so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    move_stb_d = 1'b0;
    push       = 1'b0;
    push_n     = 2'd0;
    push_bytes = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_need_input) state_d = ST_WAIT_DIGIT;
      end

      ST_WAIT_DIGIT: begin
        if (!bus.i_need_input) begin
          state_d   = ST_IDLE;
          pending_d = 4'd0;
        end else if (rx_valid && is_digit) begin
          pending_d     = digit_idx;
          push          = 1'b1;
          push_n        = 2'd1;
          push_bytes[0] = bus.i_rx_data;
          state_d       = ST_WAIT_ENTER;
        end
      end

      ST_WAIT_ENTER: begin
        if (!bus.i_need_input) begin
          state_d   = ST_IDLE;
          pending_d = 4'd0;
        end else if (rx_valid) begin
          if (is_digit) begin
            pending_d     = digit_idx;
            push          = 1'b1;
            push_n        = 2'd1;
            push_bytes[0] = bus.i_rx_data;
          end else if (is_bs) begin
            // Erase the echoed digit on the terminal: back, blank, back.
            pending_d     = 4'd0;
            push          = 1'b1;
            push_n        = 2'd3;
            push_bytes[0] = ASCII_BS;
            push_bytes[1] = ASCII_SPACE;
            push_bytes[2] = ASCII_BS;
            state_d       = ST_WAIT_DIGIT;
          end else if (is_enter) begin
            push          = 1'b1;
            push_n        = 2'd2;
            push_bytes[0] = ASCII_CR;
            push_bytes[1] = ASCII_LF;
            state_d       = ST_DELIVER;
          end
        end
      end

      ST_DELIVER: begin
        if (!bus.i_need_input) begin
          state_d   = ST_IDLE;
          pending_d = 4'd0;
        end else if (!q_busy) begin
          move_stb_d = 1'b1;
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (!bus.i_need_input) begin
          state_d   = ST_IDLE;
          pending_d = 4'd0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        pending_d = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= 4'd0;
      move_q     <= 4'd0;
      move_stb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      move_stb_q <= move_stb_d;
      if (move_stb_d) move_q <= pending_q;
    end
  end

  assign bus.o_move     = move_q;
  assign bus.o_move_stb = move_stb_q;

`ifdef MOVE_ENTRY_ECHO_EN
  logic [2:0][7:0] q_data;
  logic [1:0]      q_count;
  logic            tx_stb_q;
  logic [7:0]      tx_data_q;
  logic            issue;

  // One idle cycle after each strobe lets the transmitter raise busy before we look again.
  assign issue  = (q_count != 2'd0) && !bus.i_tx_busy && !tx_stb_q;
  assign q_busy = (q_count != 2'd0);

  // NOTE: the 3-entry queue is small enough to reset, which also guarantees
  // reset flushes it rather than leaving stale bytes behind a zero count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_data    <= '0;
      q_count   <= 2'd0;
      tx_stb_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      tx_stb_q <= issue;
      // Pushes only happen into an empty queue, so they never collide with a pop.
      if (issue) begin
        tx_data_q <= q_data[0];
        q_data    <= {8'h00, q_data[2:1]};
        q_count   <= q_count - 2'd1;
      end else if (push) begin
        q_data  <= push_bytes;
        q_count <= push_n;
      end
    end
  end

  assign bus.o_busy    = q_busy;
  assign bus.o_tx_data = tx_data_q;
  assign bus.o_tx_stb  = tx_stb_q;
`else
  assign q_busy        = 1'b0;
  assign bus.o_busy    = 1'b0;
  assign bus.o_tx_data = 8'h00;
  assign bus.o_tx_stb  = 1'b0;

  wire unused_echo = &{1'b0, push, push_n, push_bytes, bus.i_tx_busy};
`endif

endmodule

// File: tb/tb_move_entry.sv
// Directed self-checking bench for move_entry; echo-specific steps follow MOVE_ENTRY_ECHO_EN.
module tb_move_entry;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  move_entry_if bus ();

  move_entry dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int         stb_count = 0;
  int         overlap   = 0;
  int         tx_noise  = 0;
  logic [7:0] tx_log[$];

  always @(negedge clk) begin
    if (bus.o_move_stb) stb_count++;
    if (bus.o_move_stb && bus.o_busy) overlap++;
    if (bus.o_tx_stb) tx_log.push_back(bus.o_tx_data);
    if (bus.o_tx_stb || bus.o_busy || bus.o_tx_data != 8'h00) tx_noise++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (10) tick();
  endtask

  task automatic drain();
    int k = 0;
    while (bus.o_busy && k < 200) begin
      tick();
      k++;
    end
    if (k == 200) check("drain_timeout", {31'd0, bus.o_busy}, 32'd0);
  endtask

  task automatic send(input logic [7:0] b, input bit wait_drain);
    bus.i_rx_data = b;
    bus.i_rx_stb  = 1'b1;
    tick();
    bus.i_rx_stb  = 1'b0;
    bus.i_rx_data = 8'h00;
    if (wait_drain) drain();
  endtask

  task automatic check_tx(input string tag, input logic [7:0] exp[]);
    check({tag, "_len"}, tx_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < tx_log.size(); i++)
      check($sformatf("%s_%0d", tag, i), {24'd0, tx_log[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    bus.i_rx_data    = 8'h00;
    bus.i_rx_stb     = 1'b0;
    bus.i_need_input = 1'b0;
    bus.i_tx_busy    = 1'b0;

    // Reset values
    repeat (2) tick();
    check("rst_move",    {28'd0, bus.o_move},    32'd0);
    check("rst_move_stb", {31'd0, bus.o_move_stb}, 32'd0);
    check("rst_busy",    {31'd0, bus.o_busy},    32'd0);
    check("rst_tx_data", {24'd0, bus.o_tx_data}, 32'd0);
    check("rst_tx_stb",  {31'd0, bus.o_tx_stb},  32'd0);
    rst_n = 1'b1;
    tick();

    // '5' then CR -> move 4
    bus.i_need_input = 1'b1;
    tick();
    stb_count = 0;
    tx_log.delete();
    send(8'h35, 1'b1);
`ifndef MOVE_ENTRY_ECHO_EN
    send(8'h0D, 1'b0);
    check("t1_stb_at_cr", {31'd0, bus.o_move_stb}, 32'd0);
    tick();
    check("t1_stb_next", {31'd0, bus.o_move_stb}, 32'd1);
    check("t1_move_next", {28'd0, bus.o_move}, 32'd4);
    tick();
    check("t1_stb_drop", {31'd0, bus.o_move_stb}, 32'd0);
`else
    send(8'h0D, 1'b0);
`endif
    settle();
    check("t1_stb_count", stb_count, 32'd1);
    check("t1_move", {28'd0, bus.o_move}, 32'd4);
`ifdef MOVE_ENTRY_ECHO_EN
    check_tx("t1_tx", '{8'h35, 8'h0D, 8'h0A});
`endif
    bus.i_need_input = 1'b0;
    tick();

    // '2', BS, '7', LF -> move 6
    bus.i_need_input = 1'b1;
    tick();
    stb_count = 0;
    tx_log.delete();
    send(8'h32, 1'b1);
    send(8'h08, 1'b1);
    send(8'h37, 1'b1);
    send(8'h0A, 1'b0);
    settle();
    check("t2_stb_count", stb_count, 32'd1);
    check("t2_move", {28'd0, bus.o_move}, 32'd6);
`ifdef MOVE_ENTRY_ECHO_EN
    check_tx("t2_tx", '{8'h32, 8'h08, 8'h20, 8'h08, 8'h37, 8'h0D, 8'h0A});
`endif
    bus.i_need_input = 1'b0;
    tick();

    // 'A', '0', CR ignored; then '9', '3', CR -> move 2
    bus.i_need_input = 1'b1;
    tick();
    stb_count = 0;
    send(8'h41, 1'b1);
    send(8'h30, 1'b1);
    send(8'h0D, 1'b1);
    settle();
    check("t3_no_stb", stb_count, 32'd0);
    check("t3_move_held", {28'd0, bus.o_move}, 32'd6);
    send(8'h39, 1'b1);
    send(8'h33, 1'b1);
    send(8'h0D, 1'b0);
    settle();
    check("t3_stb_count", stb_count, 32'd1);
    check("t3_move", {28'd0, bus.o_move}, 32'd2);
    bus.i_need_input = 1'b0;
    tick();

`ifdef MOVE_ENTRY_ECHO_EN
    // Transmitter stalled after CR: busy holds and the strobe waits for the LF
    begin
      int busy_low = 0;
      bus.i_need_input = 1'b1;
      tick();
      stb_count = 0;
      tx_log.delete();
      send(8'h31, 1'b1);
      bus.i_tx_busy = 1'b1;
      send(8'h0D, 1'b0);
      repeat (50) begin
        if (!bus.o_busy) busy_low++;
        tick();
      end
      check("t4_busy_held", busy_low, 32'd0);
      check("t4_no_stb_stalled", stb_count, 32'd0);
      bus.i_tx_busy = 1'b0;
      settle();
      check("t4_stb_count", stb_count, 32'd1);
      check("t4_move", {28'd0, bus.o_move}, 32'd0);
      check_tx("t4_tx", '{8'h31, 8'h0D, 8'h0A});
      bus.i_need_input = 1'b0;
      tick();
    end
`endif

    // '4' then need_input drops: no strobe; CR alone afterwards: no strobe
    bus.i_need_input = 1'b1;
    tick();
    stb_count = 0;
    send(8'h34, 1'b1);
    bus.i_need_input = 1'b0;
    repeat (2) tick();
    bus.i_need_input = 1'b1;
    tick();
    send(8'h0D, 1'b1);
    settle();
    check("t5_no_stb", stb_count, 32'd0);
    send(8'h35, 1'b1);
    send(8'h0D, 1'b0);
    settle();
    check("t5_stb_count", stb_count, 32'd1);
    check("t5_move", {28'd0, bus.o_move}, 32'd4);
    bus.i_need_input = 1'b0;
    tick();

    // Async reset mid-delivery / mid-echo
    bus.i_need_input = 1'b1;
    tick();
    send(8'h36, 1'b1);
    send(8'h0D, 1'b0);
    tick();
`ifdef MOVE_ENTRY_ECHO_EN
    check("t6_pre_tx_stb", {31'd0, bus.o_tx_stb}, 32'd1);
    check("t6_pre_busy", {31'd0, bus.o_busy}, 32'd1);
`else
    check("t6_pre_move_stb", {31'd0, bus.o_move_stb}, 32'd1);
`endif
    #1 rst_n = 1'b0;
    bus.i_need_input = 1'b0;
    #1;
    check("t6_rst_tx_stb", {31'd0, bus.o_tx_stb}, 32'd0);
    check("t6_rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("t6_rst_move_stb", {31'd0, bus.o_move_stb}, 32'd0);
    check("t6_rst_move", {28'd0, bus.o_move}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // From IDLE: byte coinciding with the need_input rise is discarded
    stb_count = 0;
    bus.i_need_input = 1'b1;
    send(8'h37, 1'b1);
    send(8'h0D, 1'b1);
    settle();
    check("t7_no_stb", stb_count, 32'd0);
    send(8'h38, 1'b1);
    send(8'h0D, 1'b0);
    settle();
    check("t7_stb_count", stb_count, 32'd1);
    check("t7_move", {28'd0, bus.o_move}, 32'd7);
    bus.i_need_input = 1'b0;
    tick();

    check("stb_busy_overlap", overlap, 32'd0);
`ifndef MOVE_ENTRY_ECHO_EN
    check("tx_quiet", tx_noise, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
